// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode/funct encodings, Tuse/Tnew constants and the decoded-class payload.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TUSE_W = 2;
    localparam int unsigned CLS_TNEW_W = 2;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // COP0 rs-field selectors and fixed encodings
    localparam logic [4:0]  CP0_MF     = 5'h00;
    localparam logic [4:0]  CP0_MT     = 5'h04;
    localparam logic [4:0]  REG_EPC    = 5'd14;
    localparam logic [4:0]  REG_RA     = 5'd31;
    localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

    localparam logic [TUSE_W-1:0]     TUSE_0 = 2'd0;
    localparam logic [TUSE_W-1:0]     TUSE_1 = 2'd1;
    localparam logic [TUSE_W-1:0]     TUSE_2 = 2'd2;
    localparam logic [CLS_TNEW_W-1:0] TNEW_0 = 2'd0;
    localparam logic [CLS_TNEW_W-1:0] TNEW_1 = 2'd1;
    localparam logic [CLS_TNEW_W-1:0] TNEW_2 = 2'd2;

    // Hazard-relevant view of one decoded instruction
    typedef struct packed {
        logic                  use_rs;
        logic                  use_rt;
        logic [TUSE_W-1:0]     tuse_rs;
        logic [TUSE_W-1:0]     tuse_rt;
        logic [REG_W-1:0]      dst;
        logic [CLS_TNEW_W-1:0] tnew;
        logic                  is_md;
        logic                  is_div;
        logic                  is_mfmt;
        logic                  is_eret;
        logic                  is_mtc0_epc;
    } dec_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage facing bundle: instruction in, stall/forward controls out.
interface hazard_scoreboard_if #(
    parameter int unsigned NSTAGE = 5
);
    localparam int unsigned SEL_W = $clog2(NSTAGE - 1);

    logic [31:0]      instr_d;
    logic             valid_d;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rt_sel;
    logic             md_busy;

    modport master (
        output instr_d, valid_d, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  instr_d, valid_d, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard_instr_class_dec.sv
// Combinational classifier: source use/Tuse, destination/Tnew and special-unit flags.
module instr_class_dec
    import hazard_scoreboard_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output dec_t        cls_o
);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;

    assign op = instr_i[31:26];
    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];
    assign fn = instr_i[5:0];

    // Decode by opcode/funct; a bubble uses and writes nothing
    always_comb begin
        cls_o = '0;
        if (valid_i) begin
            case (op)
                OP_SPECIAL: begin
                    case (fn)
                        FN_SLL, FN_SRL, FN_SRA: begin
                            cls_o.use_rt = 1'b1; cls_o.tuse_rt = TUSE_1;
                            cls_o.dst = rd; cls_o.tnew = TNEW_1;
                        end
                        FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                        FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                            cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_1;
                            cls_o.use_rt = 1'b1; cls_o.tuse_rt = TUSE_1;
                            cls_o.dst = rd; cls_o.tnew = TNEW_1;
                        end
                        FN_JR: begin
                            cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_0;
                        end
                        FN_JALR: begin
                            cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_0;
                            cls_o.dst = rd; cls_o.tnew = TNEW_0;
                        end
                        FN_MFHI, FN_MFLO: begin
                            cls_o.dst = rd; cls_o.tnew = TNEW_1; cls_o.is_mfmt = 1'b1;
                        end
                        FN_MTHI, FN_MTLO: begin
                            cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_1; cls_o.is_mfmt = 1'b1;
                        end
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_1;
                            cls_o.use_rt = 1'b1; cls_o.tuse_rt = TUSE_1;
                            cls_o.is_md  = 1'b1;
                            cls_o.is_div = (fn == FN_DIV) || (fn == FN_DIVU);
                        end
                        default: ;
                    endcase
                end
                OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
                    cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_0;
                end
                OP_BEQ, OP_BNE: begin
                    cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_0;
                    cls_o.use_rt = 1'b1; cls_o.tuse_rt = TUSE_0;
                end
                OP_JAL: begin
                    cls_o.dst = REG_RA; cls_o.tnew = TNEW_0;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                    cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_1;
                    cls_o.dst = rt; cls_o.tnew = TNEW_1;
                end
                OP_LUI: begin
                    cls_o.dst = rt; cls_o.tnew = TNEW_1;
                end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_1;
                    cls_o.dst = rt; cls_o.tnew = TNEW_2;
                end
                OP_SB, OP_SH, OP_SW: begin
                    cls_o.use_rs = 1'b1; cls_o.tuse_rs = TUSE_1;
                    cls_o.use_rt = 1'b1; cls_o.tuse_rt = TUSE_2;
                end
                OP_COP0: begin
                    if (rs == CP0_MF) begin
                        cls_o.dst = rt; cls_o.tnew = TNEW_2;
                    end else if (rs == CP0_MT) begin
                        cls_o.use_rt = 1'b1; cls_o.tuse_rt = TUSE_2;
                        cls_o.is_mtc0_epc = (rd == REG_EPC);
                    end else if (instr_i == ERET_INSTR) begin
                        cls_o.is_eret = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller: tracks in-flight destinations from E to W plus mult/div occupancy.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGE   = 5,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned TNEW_W   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);
    localparam int unsigned NTRK    = NSTAGE - 2;
    localparam int unsigned SEL_W   = $clog2(NSTAGE - 1);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    dec_t cls;

    // Tracked entries, index 1 = E ... NTRK = last stage
    logic [NTRK:1]              val_q, val_d;
    logic [NTRK:1][REG_W-1:0]   dst_q, dst_d;
    logic [NTRK:1][TNEW_W-1:0]  tnew_q, tnew_d;
    logic [NTRK:1]              epc_q, epc_d;
    logic                       md1_q, md1_d;
    logic                       div1_q, div1_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic             data_stall, md_stall, eret_stall, stall_c;
    logic [SEL_W-1:0] rs_sel, rt_sel;
    logic [4:0]       src_rs, src_rt;

    assign src_rs = bus.instr_d[25:21];
    assign src_rt = bus.instr_d[20:16];

    instr_class_dec u_dec (
        .instr_i (bus.instr_d),
        .valid_i (bus.valid_d),
        .cls_o   (cls)
    );

    // Compare D sources against every entry; descending scan leaves the youngest match
    always_comb begin
        data_stall = 1'b0;
        eret_stall = 1'b0;
        rs_sel     = '0;
        rt_sel     = '0;
        for (int k = int'(NTRK); k >= 1; k--) begin
            if (val_q[k] && (dst_q[k] != '0)) begin
                if (cls.use_rs && (dst_q[k] == src_rs)) begin
                    if (32'(tnew_q[k]) > 32'(cls.tuse_rs)) data_stall = 1'b1;
                    if (tnew_q[k] == '0) rs_sel = SEL_W'(k);
                end
                if (cls.use_rt && (dst_q[k] == src_rt)) begin
                    if (32'(tnew_q[k]) > 32'(cls.tuse_rt)) data_stall = 1'b1;
                    if (tnew_q[k] == '0) rt_sel = SEL_W'(k);
                end
            end
            if (val_q[k] && epc_q[k] && cls.is_eret) eret_stall = 1'b1;
        end
    end

    assign md_stall = (cls.is_md || cls.is_mfmt) && ((cnt_q != '0) || (val_q[1] && md1_q));
    assign stall_c  = data_stall || md_stall || eret_stall;

    // Advance entries, load E from D unless stalled/flushed, run the mult/div counter
    always_comb begin
        val_d  = '0;
        dst_d  = '0;
        tnew_d = '0;
        epc_d  = '0;
        md1_d  = 1'b0;
        div1_d = 1'b0;
        cnt_d  = cnt_q;
        if (!bus.flush && !stall_c) begin
            val_d[1]  = bus.valid_d;
            dst_d[1]  = cls.dst;
            tnew_d[1] = TNEW_W'(cls.tnew);
            epc_d[1]  = cls.is_mtc0_epc;
            md1_d     = cls.is_md;
            div1_d    = cls.is_div;
        end
        for (int k = 2; k <= int'(NTRK); k++) begin
            val_d[k]  = val_q[k-1] && !bus.flush;
            dst_d[k]  = dst_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
            epc_d[k]  = epc_q[k-1];
        end
        if (val_q[1] && md1_q && !bus.flush) begin
            cnt_d = div1_q ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            dst_q  <= '0;
            tnew_q <= '0;
            epc_q  <= '0;
            md1_q  <= 1'b0;
            div1_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            val_q  <= val_d;
            dst_q  <= dst_d;
            tnew_q <= tnew_d;
            epc_q  <= epc_d;
            md1_q  <= md1_d;
            div1_q <= div1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.fwd_rs_sel = rs_sel;
    assign bus.fwd_rt_sel = rt_sel;
    assign bus.md_busy    = (cnt_q != '0);
endmodule
